// File: rtl/data_mem_responder.sv
// Word-organised data memory answering RISC-V style byte/half/word loads and stores
// after a fixed LATENCY. Optional MISALIGN_TRAP_EN turns misaligned accesses into errors.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int LW = AW + 2;
   localparam logic [3:0] LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_cnt;

   logic          r_we;
   logic [2:0]    r_size;
   logic [LW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_accept;
   logic          w_enter_resp;
   logic          w_use_in;
   logic          w_we;
   logic [2:0]    w_size;
   logic [LW-1:0] w_addr;
   logic [31:0]   w_wdata;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_word;
   logic          w_misalign;
   logic          w_err;
   logic [3:0]    w_strb;
   logic [31:0]   w_wlanes;
   logic          w_unused_addr;

   function automatic logic f_err(input logic we, input logic [2:0] size,
                                  input logic misalign);
      logic e;
      case (size)
         3'b000, 3'b001, 3'b010: e = 1'b0;
         3'b100, 3'b101:         e = we;
         default:                e = 1'b1;
      endcase
      return e | misalign;
   endfunction

   function automatic logic [3:0] f_strb(input logic [2:0] size, input logic [1:0] off);
      logic [3:0] s;
      case (size[1:0])
         2'b00:   s = 4'b0001 << off;
         2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   // Replicate the right-aligned store data across lanes; the strobe picks the live ones.
   function automatic logic [31:0] f_wlanes(input logic [2:0] size, input logic [31:0] wd);
      logic [31:0] d;
      case (size[1:0])
         2'b00:   d = {4{wd[7:0]}};
         2'b01:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] f_load(input logic [2:0] size, input logic [1:0] off,
                                          input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(word >> {off, 3'b000});
      h = 16'(word >> {off[1], 4'b0000});
      case (size)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b010:  r = word;
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   assign w_accept     = (r_state == S_IDLE) && req_valid;
   // With LATENCY=0 the commit happens on the accept edge, before the latches hold the request.
   assign w_use_in     = (r_state == S_IDLE);
   assign w_we         = w_use_in ? req_we            : r_we;
   assign w_size       = w_use_in ? req_size          : r_size;
   assign w_addr       = w_use_in ? req_addr[LW-1:0]  : r_addr;
   assign w_wdata      = w_use_in ? req_wdata         : r_wdata;
   assign w_idx        = w_addr[LW-1:2];
   assign w_word       = r_mem[w_idx];
   assign w_unused_addr = ^req_addr[31:LW];

`ifdef MISALIGN_TRAP_EN
   assign w_misalign = ((w_size[1:0] == 2'b01) && w_addr[0]) ||
                       ((w_size == 3'b010) && (w_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_err        = f_err(w_we, w_size, w_misalign);
   assign w_strb       = f_strb(w_size, w_addr[1:0]);
   assign w_wlanes     = f_wlanes(w_size, w_wdata);
   assign w_enter_resp = rst && (r_state != S_RESP) && (w_next == S_RESP);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (LATENCY == 0) w_next = S_RESP;
               else              w_next = S_WAIT;
            end
         end
         S_WAIT: if (r_cnt == LAST) w_next = S_RESP;
         S_RESP: if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if ((r_state == S_WAIT) && (w_next == S_WAIT)) r_cnt <= r_cnt + 4'd1;
         else                                           r_cnt <= 4'd0;
         if (w_enter_resp) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_we) ? 32'd0 : f_load(w_size, w_addr[1:0], w_word);
         end
      end
   end

   // Request fields: captured on accept only, never reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we    <= req_we;
         r_size  <= req_size;
         r_addr  <= req_addr[LW-1:0];
         r_wdata <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (w_enter_resp && w_we && !w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
         end
      end
   end

   assign req_ready = rst && (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule
